// File: rtl/share_sequencer.sv
// share_sequencer: splits each accepted word into d+1 Boolean shares.
// One fresh random mask is taken per RNG beat. Share 0 is the data XORed
// with every mask, and shares 1..d are the masks in the order they arrived.
// Shares are held in registers and gated to zero whenever out_valid is low,
// so a partly built word never appears on the output.
//
// state | meaning
// IDLE  | waiting for an input word (in_ready high)
// FETCH | collecting d random masks, one per rnd handshake
// OUT   | shares presented and held until the consumer accepts them
module share_sequencer #(
   parameter int d        = 2,
   parameter int COL_SIZE = 5,
   parameter int PAR      = 1,
   localparam int W       = COL_SIZE * PAR
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         data_in,
   input  logic                 rnd_valid,
   output logic                 rnd_ready,
   input  logic [W-1:0]         rnd_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [(d+1)*W-1:0]   shares_out,
   output logic                 busy
);

   localparam int CW = $clog2(d + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] OUT   = 2'd2;

   logic [1:0]    state;
   logic [W-1:0]  acc;
   logic [W-1:0]  mask [d];
   logic [CW-1:0] cnt;

   // Handshake flags are decoded directly from the state.
   assign in_ready  = (state == IDLE);
   assign rnd_ready = (state == FETCH);
   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE);

   // Sequencing of acceptance, mask collection and hand-off; any other
   // input activity outside the accepting state is simply ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         for (int i = 0; i < d; i++) mask[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc   <= data_in;
                  cnt   <= '0;
                  state <= FETCH;
               end
            end
            FETCH: begin
               if (rnd_valid) begin
                  for (int i = 0; i < d; i++) begin
                     if (cnt == CW'(i)) mask[i] <= rnd_data;
                  end
                  acc <= acc ^ rnd_data;
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(d - 1)) state <= OUT;
               end
            end
            OUT: begin
               // Wipe the secret material as soon as the consumer has it.
               if (out_ready) begin
                  acc   <= '0;
                  cnt   <= '0;
                  for (int i = 0; i < d; i++) mask[i] <= '0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Pack the shares for output, forced to zero outside OUT.
   always_comb begin
      shares_out = '0;
      if (state == OUT) begin
         shares_out[0 +: W] = acc;
         for (int i = 0; i < d; i++) begin
            shares_out[(i+1)*W +: W] = mask[i];
         end
      end
   end

endmodule

// File: tb/tb_share_sequencer.sv
// Bench for share_sequencer with d=2, COL_SIZE=5, PAR=1.
module tb_share_sequencer;

   localparam int W  = 5;
   localparam int SW = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  data_in;
   logic          rnd_valid;
   logic          rnd_ready;
   logic [W-1:0]  rnd_data;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] shares_out;
   logic          busy;

   int total = 0;
   int bad   = 0;
   int rnd_hs = 0;

   logic [SW-1:0] sb_q [$];

   typedef struct {
      logic [W-1:0]  data;
      logic [W-1:0]  m0;
      logic [W-1:0]  m1;
      int            gap;
      int            stall;
      logic [SW-1:0] exp;
   } vec_t;

   vec_t vecs [6];

   share_sequencer #(.d(2), .COL_SIZE(5), .PAR(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_in    (data_in),
      .rnd_valid  (rnd_valid),
      .rnd_ready  (rnd_ready),
      .rnd_data   (rnd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .shares_out (shares_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && rnd_valid && rnd_ready) rnd_hs <= rnd_hs + 1;
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),   32'd1);
      chk({tag, "_rnd_ready"}, 32'(rnd_ready),  32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid),  32'd0);
      chk({tag, "_busy"},      32'(busy),       32'd0);
      chk({tag, "_shares"},    32'(shares_out), 32'd0);
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      logic [SW-1:0] held;
      logic [SW-1:0] e;
      int hs0;
      string t;
      t = $sformatf("v%0d", idx);
      hs0 = rnd_hs;
      chk({t, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      data_in  = v.data;
      sb_q.push_back(v.exp);
      tick();
      in_valid = 1'b0;
      data_in  = W'($urandom);
      chk({t, "_fetch_rnd_ready"}, 32'(rnd_ready), 32'd1);
      chk({t, "_fetch_in_ready"}, 32'(in_ready), 32'd0);
      rnd_valid = 1'b1;
      rnd_data  = v.m0;
      tick();
      for (int g = 0; g < v.gap; g++) begin
         rnd_valid = 1'b0;
         rnd_data  = W'($urandom);
         chk({t, "_starve_out_valid"}, 32'(out_valid), 32'd0);
         chk({t, "_starve_shares"}, 32'(shares_out), 32'd0);
         tick();
      end
      chk({t, "_pre_last_out_valid"}, 32'(out_valid), 32'd0);
      rnd_valid = 1'b1;
      rnd_data  = v.m1;
      tick();
      rnd_valid = 1'b0;
      chk({t, "_latency_out_valid"}, 32'(out_valid), 32'd1);
      held = shares_out;
      for (int s = 0; s < v.stall; s++) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         rnd_valid = 1'b1;
         rnd_data  = W'($urandom);
         chk({t, "_stall_valid"}, 32'(out_valid), 32'd1);
         chk({t, "_stall_stable"}, 32'(shares_out), 32'(held));
         chk({t, "_stall_in_ready"}, 32'(in_ready), 32'd0);
         chk({t, "_stall_rnd_ready"}, 32'(rnd_ready), 32'd0);
         chk({t, "_stall_busy"}, 32'(busy), 32'd1);
         tick();
      end
      in_valid  = 1'b0;
      rnd_valid = 1'b0;
      out_ready = 1'b1;
      chk({t, "_out_valid"}, 32'(out_valid), 32'd1);
      if (sb_q.size() == 0) begin
         chk({t, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({t, "_shares"}, 32'(shares_out), 32'(e));
      end
      chk({t, "_xor"}, 32'(shares_out[14:10] ^ shares_out[9:5] ^ shares_out[4:0]), 32'(v.data));
      chk({t, "_rnd_hs"}, rnd_hs - hs0, 32'd2);
      tick();
      out_ready = 1'b0;
      chk_idle({t, "_after"});
   endtask

   initial begin
      logic [SW-1:0] e;
      logic [W-1:0]  r1, r2, dk;

      vecs[0] = '{5'h15, 5'h0A, 5'h03, 0, 0, {5'h03, 5'h0A, 5'h1C}};
      vecs[1] = '{5'h15, 5'h0A, 5'h03, 3, 0, {5'h03, 5'h0A, 5'h1C}};
      vecs[2] = '{5'h15, 5'h0A, 5'h03, 0, 4, {5'h03, 5'h0A, 5'h1C}};
      vecs[3] = '{5'h0B, 5'h00, 5'h00, 0, 0, {5'h00, 5'h00, 5'h0B}};
      vecs[4] = '{5'h1F, 5'h01, 5'h02, 0, 0, {5'h02, 5'h01, 5'h1C}};
      vecs[5] = '{5'h00, 5'h1F, 5'h1F, 1, 2, {5'h1F, 5'h1F, 5'h00}};

      rst = 1'b1;
      in_valid = 1'b1;
      data_in = 5'h1F;
      rnd_valid = 1'b1;
      rnd_data = 5'h11;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      rnd_valid = 1'b0;
      out_ready = 1'b0;
      chk_idle("reset");

      for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

      // Reset while collecting masks: nothing from the aborted word may leak.
      in_valid = 1'b1;
      data_in = 5'h15;
      tick();
      in_valid = 1'b0;
      rnd_valid = 1'b1;
      rnd_data = 5'h0A;
      tick();
      rnd_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_idle("fetch_reset");
      tick();
      chk_idle("fetch_reset_hold");
      run_txn('{5'h1F, 5'h01, 5'h02, 0, 0, {5'h02, 5'h01, 5'h1C}}, 10);

      // Back-to-back with every valid/ready held high: one word per 4 cycles.
      in_valid = 1'b1;
      rnd_valid = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         dk = W'(5'h05 + c / 4);
         data_in = dk;
         rnd_data = W'(c * 7 + 1);
         if (c % 4 == 0) begin
            chk($sformatf("b2b_in_ready_c%0d", c), 32'(in_ready), 32'd1);
            r1 = W'((c + 1) * 7 + 1);
            r2 = W'((c + 2) * 7 + 1);
            sb_q.push_back({r2, r1, dk ^ r1 ^ r2});
         end
         if (c % 4 == 3) begin
            chk($sformatf("b2b_out_valid_c%0d", c), 32'(out_valid), 32'd1);
            if (sb_q.size() == 0) begin
               chk("b2b_sb_empty", 32'd0, 32'd1);
            end else begin
               e = sb_q.pop_front();
               chk($sformatf("b2b_shares_c%0d", c), 32'(shares_out), 32'(e));
            end
         end else begin
            chk($sformatf("b2b_out_valid_c%0d", c), 32'(out_valid), 32'd0);
            chk($sformatf("b2b_zero_c%0d", c), 32'(shares_out), 32'd0);
         end
         tick();
      end
      in_valid = 1'b0;
      rnd_valid = 1'b0;
      out_ready = 1'b0;
      chk_idle("b2b_end");
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
